// File: rtl/bc_pkg.sv
// Shared encodings for the basic-computer control sequencer: bus sources,
// ALU operations, memory-reference opcodes and sequence-counter sizing.
package bc_pkg;

  localparam int SC_W  = 4;
  localparam int T_MAX = (1 << SC_W) - 1;

  // Common bus source select codes (6 is unused).
  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd7
  } bus_sel_t;

  // ALU function codes driven alongside ld_ac.
  typedef enum logic [2:0] {
    ALU_DR  = 3'd0,
    ALU_AND = 3'd1,
    ALU_ADD = 3'd2,
    ALU_CMA = 3'd3,
    ALU_CIR = 3'd4,
    ALU_CIL = 3'd5,
    ALU_INC = 3'd6
  } alu_op_t;

  // IR[14:12] opcode names; OP_IO (D7) covers register-reference and I/O.
  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_IO  = 3'd7
  } opcode_t;

  // Start/stop flip-flop S.
  typedef enum logic {
    S_HALT = 1'b0,
    S_RUN  = 1'b1
  } run_state_t;

  // Isolate the lowest set bit so register-reference decode sees one-hot bits.
  function automatic logic [11:0] lowest_set(input logic [11:0] v);
    return v & (~v + 12'd1);
  endfunction

endpackage

// File: rtl/bc_seq_counter.sv
// Sequence counter SC with clear/increment/hold and a one-hot T0..Tn decode.
module bc_seq_counter #(
  parameter int SC_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [SC_W-1:0]        sc,
  output logic [(1<<SC_W)-1:0]   timing
);

  logic [SC_W-1:0] sc_reg;
  logic [SC_W-1:0] sc_next;

  // Clear has priority over increment; otherwise the count holds.
  always_comb begin
    sc_next = sc_reg;
    if (clr) begin
      sc_next = '0;
    end else if (inc) begin
      sc_next = sc_reg + SC_W'(1);
    end
  end

  // Counter register, returns to T0 immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_reg <= '0;
    end else begin
      sc_reg <= sc_next;
    end
  end

  assign sc = sc_reg;

  genvar gi;
  generate
    for (gi = 0; gi < (1 << SC_W); gi++) begin : g_timing
      assign timing[gi] = (sc_reg == SC_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/bc_control_sequencer.sv
// Timing/control unit of the basic computer: S flip-flop, opcode decode and the
// per-T-state strobe generation for the fetch/indirect/execute phases.
module bc_control_sequencer #(
  parameter int AW   = 12,
  parameter int SC_W = bc_pkg::SC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          ir,
  input  logic                 ac_msb,
  input  logic                 ac_zero,
  input  logic                 e_flag,
  input  logic                 dr_zero,
  output logic [2:0]           bus_sel,
  output logic                 ld_ar,
  output logic                 ld_pc,
  output logic                 ld_dr,
  output logic                 ld_ac,
  output logic                 ld_ir,
  output logic                 inc_ar,
  output logic                 inc_pc,
  output logic                 inc_dr,
  output logic                 clr_ac,
  output logic                 clr_e,
  output logic                 cmp_e,
  output logic [2:0]           alu_op,
  output logic                 mem_wr,
  output logic [(1<<SC_W)-1:0] timing,
  output logic                 running
);
  import bc_pkg::*;

  localparam int T_LAST = (1 << SC_W) - 1;

  run_state_t      s_reg, s_next;
  logic            i_reg, i_next;
  logic [SC_W-1:0] sc;
  logic            sc_clr;
  logic            halt_req;
  logic [7:0]      d;
  logic [AW-1:0]   addr_bits;
  logic [11:0]     rr_sel;

  bc_seq_counter #(.SC_W(SC_W)) u_sc (
    .clk    (clk),
    .rst    (rst),
    .clr    (sc_clr),
    .inc    (running),
    .sc     (sc),
    .timing (timing)
  );

  assign running   = (s_reg == S_RUN);
  assign addr_bits = ir[AW-1:0];
  assign rr_sel    = lowest_set(addr_bits[11:0]);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      assign d[gi] = (ir[14:12] == 3'(gi));
    end
  endgenerate

  // S flip-flop and the indirect bit captured at T2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg <= S_HALT;
      i_reg <= 1'b0;
    end else begin
      s_reg <= s_next;
      i_reg <= i_next;
    end
  end

  // Run/halt transitions: HLT leaves S, start only acts while halted.
  always_comb begin
    s_next = s_reg;
    i_next = i_reg;
    if (s_reg == S_RUN) begin
      if (halt_req) begin
        s_next = S_HALT;
      end
      if (sc == SC_W'(2)) begin
        i_next = ir[15];
      end
    end else if (start) begin
      s_next = S_RUN;
    end
  end

  // Strobes for the current T-state; everything idle while halted.
  always_comb begin
    bus_sel  = BUS_NONE;
    ld_ar    = 1'b0;
    ld_pc    = 1'b0;
    ld_dr    = 1'b0;
    ld_ac    = 1'b0;
    ld_ir    = 1'b0;
    inc_ar   = 1'b0;
    inc_pc   = 1'b0;
    inc_dr   = 1'b0;
    clr_ac   = 1'b0;
    clr_e    = 1'b0;
    cmp_e    = 1'b0;
    alu_op   = ALU_DR;
    mem_wr   = 1'b0;
    sc_clr   = 1'b0;
    halt_req = 1'b0;
    if (s_reg != S_RUN) begin
      sc_clr = 1'b1;
    end else if (sc == SC_W'(T_LAST)) begin
      // Runaway sequence: recover to T0 without touching the datapath.
      sc_clr = 1'b1;
    end else begin
      case (int'(sc))
        0: begin
          bus_sel = BUS_PC;
          ld_ar   = 1'b1;
        end
        1: begin
          bus_sel = BUS_MEM;
          ld_ir   = 1'b1;
          inc_pc  = 1'b1;
        end
        2: begin
          bus_sel = BUS_IR;
          ld_ar   = 1'b1;
        end
        3: begin
          if (d[OP_IO]) begin
            sc_clr = 1'b1;
            if (!i_reg) begin
              if (rr_sel[11]) clr_ac = 1'b1;
              if (rr_sel[10]) clr_e  = 1'b1;
              if (rr_sel[9]) begin ld_ac = 1'b1; alu_op = ALU_CMA; end
              if (rr_sel[8]) cmp_e = 1'b1;
              if (rr_sel[7]) begin ld_ac = 1'b1; alu_op = ALU_CIR; end
              if (rr_sel[6]) begin ld_ac = 1'b1; alu_op = ALU_CIL; end
              if (rr_sel[5]) begin ld_ac = 1'b1; alu_op = ALU_INC; end
              if (rr_sel[4] && !ac_msb)  inc_pc = 1'b1;
              if (rr_sel[3] && ac_msb)   inc_pc = 1'b1;
              if (rr_sel[2] && ac_zero)  inc_pc = 1'b1;
              if (rr_sel[1] && !e_flag)  inc_pc = 1'b1;
              if (rr_sel[0]) halt_req = 1'b1;
            end
          end else if (i_reg) begin
            bus_sel = BUS_MEM;
            ld_ar   = 1'b1;
          end
        end
        4: begin
          if (d[OP_AND] || d[OP_ADD] || d[OP_LDA] || d[OP_ISZ]) begin
            bus_sel = BUS_MEM;
            ld_dr   = 1'b1;
          end else if (d[OP_STA]) begin
            bus_sel = BUS_AC;
            mem_wr  = 1'b1;
            sc_clr  = 1'b1;
          end else if (d[OP_BUN]) begin
            bus_sel = BUS_AR;
            ld_pc   = 1'b1;
            sc_clr  = 1'b1;
          end else if (d[OP_BSA]) begin
            bus_sel = BUS_PC;
            mem_wr  = 1'b1;
            inc_ar  = 1'b1;
          end
        end
        5: begin
          if (d[OP_AND] || d[OP_ADD] || d[OP_LDA]) begin
            ld_ac  = 1'b1;
            alu_op = d[OP_AND] ? ALU_AND : (d[OP_ADD] ? ALU_ADD : ALU_DR);
            sc_clr = 1'b1;
          end else if (d[OP_BSA]) begin
            bus_sel = BUS_AR;
            ld_pc   = 1'b1;
            sc_clr  = 1'b1;
          end else if (d[OP_ISZ]) begin
            inc_dr = 1'b1;
          end
        end
        6: begin
          if (d[OP_ISZ]) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            inc_pc  = dr_zero;
            sc_clr  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
